// File: rtl/freq_meas_sched.sv
// freq_meas_sched: round-robin frequency measurement scheduler.
// One shared gated edge counter is time-multiplexed across up to 8
// asynchronous inputs. Each finished measurement lands in a per-channel
// result bank that the MCU readout path indexes through rd_ch.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | not measuring; waits for run with at least one channel on
// SELECT | pick next enabled channel, latch gate length, clear counters
// SETTLE | SETTLE cycles after the switch; edges ignored
// GATE   | G cycles of counting edges of the selected channel
// STORE  | write the count into the bank, then back to SELECT
module freq_meas_sched #(
    parameter int NCH    = 4,
    parameter int GATE   = 96000000,
    parameter int SETTLE = 4,
    parameter int CW     = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NCH-1:0]  sig_in,
    input  logic [NCH-1:0]  ch_en,
    input  logic            run,
    input  logic [31:0]     gate_cycles,
    input  logic [2:0]      rd_ch,
    output logic [CW-1:0]   rd_data,
    output logic            rd_valid,
    output logic            busy,
    output logic [2:0]      meas_ch,
    output logic            done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_SETTLE,
        S_GATE,
        S_STORE
    } state_t;

    // Settle timer is a down-counter loaded with SETTLE-1.
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE - 1);

    // All-ones is reserved as "no result", so the count stops one below it.
    localparam logic [CW-1:0] CNT_SAT   = {{(CW-1){1'b1}}, 1'b0};
    localparam logic [CW-1:0] NO_RESULT = '1;
    localparam logic [31:0]   GATE_DEF  = 32'(GATE);
    localparam logic [3:0]    NCH_W     = 4'(NCH);

    state_t            state;
    logic [NCH-1:0]    sync1;
    logic [NCH-1:0]    sync2;
    logic [NCH-1:0]    hist;
    logic [7:0]        edge_all;
    logic [7:0]        en_all;
    logic              edge_sel;

    logic [31:0]       gate_len;
    logic [31:0]       gate_cnt;
    logic [CW-1:0]     edge_cnt;
    logic [SW-1:0]     settle_cnt;

    // Bank is sized for the full 3-bit index; entries at or above NCH are
    // never written and stay at their reset value.
    logic [CW-1:0]     bank [8];
    logic [7:0]        valid;

    logic [2:0]        nxt_hi;
    logic              nxt_hi_found;
    logic [2:0]        nxt_lo;
    logic              nxt_lo_found;
    logic [2:0]        sel_ch;
    logic              sel_any;
    logic              store_now;

    // Per-channel 2-flop synchronizer plus history flop, free-running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            hist  <= '0;
        end else begin
            sync1 <= sig_in;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    assign edge_all = 8'(sync2 & ~hist);
    assign en_all   = 8'(ch_en);
    assign edge_sel = edge_all[meas_ch];

    // Round-robin pick: lowest enabled index above meas_ch, else lowest enabled.
    always_comb begin
        nxt_hi       = '0;
        nxt_hi_found = 1'b0;
        nxt_lo       = '0;
        nxt_lo_found = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (en_all[i]) begin
                nxt_lo       = 3'(i);
                nxt_lo_found = 1'b1;
                if (3'(i) > meas_ch) begin
                    nxt_hi       = 3'(i);
                    nxt_hi_found = 1'b1;
                end
            end
        end
    end

    assign sel_ch    = nxt_hi_found ? nxt_hi : nxt_lo;
    assign sel_any   = nxt_lo_found;
    assign store_now = (state == S_STORE) && run;

    // Scheduler FSM with registered busy/done/meas_ch and bank update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            meas_ch    <= 3'(NCH - 1);
            gate_len   <= GATE_DEF;
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            settle_cnt <= '0;
            valid      <= '0;
            for (int i = 0; i < 8; i++) begin
                bank[i] <= NO_RESULT;
            end
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (run && (|ch_en)) begin
                        state <= S_SELECT;
                        busy  <= 1'b1;
                    end
                end

                S_SELECT: begin
                    if (!run || !sel_any) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        meas_ch    <= sel_ch;
                        gate_len   <= (gate_cycles == 32'd0) ? GATE_DEF : gate_cycles;
                        gate_cnt   <= '0;
                        edge_cnt   <= '0;
                        settle_cnt <= SETTLE_LOAD;
                        state      <= S_SETTLE;
                    end
                end

                S_SETTLE: begin
                    if (!run) begin
                        state    <= S_IDLE;
                        busy     <= 1'b0;
                        edge_cnt <= '0;
                    end else if (settle_cnt == '0) begin
                        state <= S_GATE;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end

                S_GATE: begin
                    if (!run) begin
                        state    <= S_IDLE;
                        busy     <= 1'b0;
                        edge_cnt <= '0;
                        gate_cnt <= '0;
                    end else begin
                        if (edge_sel && (edge_cnt != CNT_SAT)) begin
                            edge_cnt <= edge_cnt + 1'b1;
                        end
                        if (gate_cnt == (gate_len - 32'd1)) begin
                            state <= S_STORE;
                        end else begin
                            gate_cnt <= gate_cnt + 32'd1;
                        end
                    end
                end

                S_STORE: begin
                    if (!run) begin
                        state    <= S_IDLE;
                        busy     <= 1'b0;
                        edge_cnt <= '0;
                        gate_cnt <= '0;
                    end else begin
                        bank[meas_ch]  <= edge_cnt;
                        valid[meas_ch] <= 1'b1;
                        done           <= 1'b1;
                        state          <= S_SELECT;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Registered readout; bypasses the value being stored so the done
    // cycle already shows the new result for the measured channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= NO_RESULT;
            rd_valid <= 1'b0;
        end else if ({1'b0, rd_ch} >= NCH_W) begin
            rd_data  <= NO_RESULT;
            rd_valid <= 1'b0;
        end else if (store_now && (rd_ch == meas_ch)) begin
            rd_data  <= edge_cnt;
            rd_valid <= 1'b1;
        end else begin
            rd_data  <= bank[rd_ch];
            rd_valid <= valid[rd_ch];
        end
    end

endmodule

// File: tb/tb_freq_meas_sched.sv
// Bench for freq_meas_sched: scoreboard of expected per-measurement results,
// a readout vector table, and hand-written abort/reset sequences.
module tb_freq_meas_sched;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        run;
    logic [3:0]  ch_en;
    logic [31:0] gate_cycles;
    logic [2:0]  rd_ch;
    logic [2:0]  rd_ch_drv;
    logic        follow;
    logic        sig_on;
    logic [7:0]  tick = 8'd0;
    logic [3:0]  sig_in;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        busy;
    logic [2:0]  meas_ch;
    logic        done;

    logic        run1;
    logic [31:0] gate_cycles1;
    logic [2:0]  rd_ch1;
    logic [0:0]  sig_in1;
    logic [0:0]  ch_en1;
    logic [3:0]  rd_data1;
    logic        rd_valid1;
    logic        busy1;
    logic [2:0]  meas_ch1;
    logic        done1;

    // Input patterns: ch0 period 2, ch1 period 4, ch2 period 2, ch3 period 8.
    always @(negedge clk) tick <= tick + 8'd1;
    assign sig_in  = sig_on ? {tick[2], tick[0], tick[1], tick[0]} : 4'b0000;
    assign sig_in1 = sig_on ? tick[0] : 1'b0;
    assign ch_en1  = 1'b1;
    assign rd_ch   = follow ? meas_ch : rd_ch_drv;

    freq_meas_sched #(.NCH(4), .GATE(20), .SETTLE(4), .CW(32)) dut (
        .clk(clk), .rst(rst), .sig_in(sig_in), .ch_en(ch_en), .run(run),
        .gate_cycles(gate_cycles), .rd_ch(rd_ch), .rd_data(rd_data),
        .rd_valid(rd_valid), .busy(busy), .meas_ch(meas_ch), .done(done)
    );

    freq_meas_sched #(.NCH(1), .GATE(20), .SETTLE(4), .CW(4)) dut_sat (
        .clk(clk), .rst(rst), .sig_in(sig_in1), .ch_en(ch_en1), .run(run1),
        .gate_cycles(gate_cycles1), .rd_ch(rd_ch1), .rd_data(rd_data1),
        .rd_valid(rd_valid1), .busy(busy1), .meas_ch(meas_ch1), .done(done1)
    );

    typedef struct {
        int     ch;
        longint lo;
        longint hi;
    } exp_t;

    typedef struct {
        logic [2:0] ch;
        bit         valid;
        longint     lo;
        longint     hi;
    } rd_vec_t;

    exp_t    sb[$];
    rd_vec_t tbl[8];
    int      n_pass = 0;
    int      n_tot  = 0;

    localparam longint ONES32 = 64'h0000_0000_FFFF_FFFF;

    task automatic chk(input string name, input longint act, input longint lo, input longint hi);
        n_tot++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    endtask

    task automatic push(input int ch, input longint lo, input longint hi);
        exp_t e;
        e.ch = ch; e.lo = lo; e.hi = hi;
        sb.push_back(e);
    endtask

    task automatic wait_done(input bit which, input int budget, output int cyc, output bit ok);
        ok  = 1'b0;
        cyc = 0;
        while (!ok && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if ((which ? done1 : done) == 1'b1) ok = 1'b1;
        end
    endtask

    // Pops the next expected measurement and compares it at the done pulse.
    task automatic sb_next(input string tag, output int cyc);
        exp_t e;
        bit   ok;
        if (sb.size() == 0) begin
            $display("FAIL %s_sb: got empty scoreboard, expected an entry", tag);
            n_tot++;
            cyc = 0;
            return;
        end
        e = sb.pop_front();
        wait_done(1'b0, 400, cyc, ok);
        chk({tag, "_done"}, longint'(ok), 1, 1);
        chk({tag, "_ch"}, longint'(meas_ch), e.ch, e.ch);
        chk({tag, "_data"}, longint'(rd_data), e.lo, e.hi);
        chk({tag, "_valid"}, longint'(rd_valid), 1, 1);
    endtask

    initial begin
        int cyc;
        bit ok;
        int ndone;

        tbl[0] = '{3'd0, 1'b1, 25, 25};
        tbl[1] = '{3'd1, 1'b1, 12, 13};
        tbl[2] = '{3'd2, 1'b0, ONES32, ONES32};
        tbl[3] = '{3'd3, 1'b1, 6, 7};
        tbl[4] = '{3'd4, 1'b0, ONES32, ONES32};
        tbl[5] = '{3'd5, 1'b0, ONES32, ONES32};
        tbl[6] = '{3'd6, 1'b0, ONES32, ONES32};
        tbl[7] = '{3'd7, 1'b0, ONES32, ONES32};

        rst = 1'b1; run = 1'b0; ch_en = 4'b0000; gate_cycles = 32'd0;
        rd_ch_drv = 3'd0; follow = 1'b0; sig_on = 1'b1;
        run1 = 1'b0; gate_cycles1 = 32'd0; rd_ch1 = 3'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("rst_busy", longint'(busy), 0, 0);
        chk("rst_rd_data", longint'(rd_data), ONES32, ONES32);
        chk("rst_rd_valid", longint'(rd_valid), 0, 0);
        chk("rst_done", longint'(done), 0, 0);
        chk("rst_meas_ch", longint'(meas_ch), 3, 3);
        chk("rst_sat_rd_data", longint'(rd_data1), 15, 15);

        // Round robin over ch0/1/3, ch2 disabled.
        ch_en = 4'b1011; gate_cycles = 32'd50; follow = 1'b1; run = 1'b1;
        @(negedge clk);
        chk("busy_rise", longint'(busy), 1, 1);
        for (int k = 0; k < 2; k++) begin
            push(0, 25, 25);
            push(1, 12, 13);
            push(3, 6, 7);
        end
        for (int k = 0; k < 6; k++) begin
            sb_next("rr", cyc);
            if (k > 0) chk("rr_period", cyc, 56, 56);
        end
        run = 1'b0;
        @(negedge clk);
        chk("abort_busy", longint'(busy), 0, 0);
        chk("abort_meas_ch", longint'(meas_ch), 3, 3);

        follow = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rd_ch_drv = tbl[i].ch;
            @(negedge clk);
            chk($sformatf("rd_data_ch%0d", i), longint'(rd_data), tbl[i].lo, tbl[i].hi);
            chk($sformatf("rd_valid_ch%0d", i), longint'(rd_valid), longint'(tbl[i].valid), longint'(tbl[i].valid));
        end

        // ch1 gives 20, then abort mid-gate on ch1.
        ch_en = 4'b0110; gate_cycles = 32'd80; follow = 1'b1; run = 1'b1;
        push(1, 20, 20);
        push(2, 40, 40);
        sb_next("ab1", cyc);
        sb_next("ab2", cyc);
        chk("ab_period", cyc, 86, 86);
        repeat (30) @(negedge clk);
        chk("mid_gate_ch", longint'(meas_ch), 1, 1);
        chk("mid_gate_busy", longint'(busy), 1, 1);
        run = 1'b0;
        @(negedge clk);
        chk("drop_busy", longint'(busy), 0, 0);
        ndone = (done == 1'b1) ? 1 : 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done == 1'b1) ndone++;
        end
        chk("drop_no_done", ndone, 0, 0);
        chk("drop_meas_ch", longint'(meas_ch), 1, 1);
        follow = 1'b0; rd_ch_drv = 3'd1;
        @(negedge clk);
        chk("drop_keep_data", longint'(rd_data), 20, 20);
        chk("drop_keep_valid", longint'(rd_valid), 1, 1);
        follow = 1'b1; run = 1'b1;
        push(2, 40, 40);
        sb_next("restart", cyc);

        // Asynchronous reset mid-gate, away from any clock edge.
        repeat (20) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", longint'(busy), 0, 0);
        chk("arst_rd_data", longint'(rd_data), ONES32, ONES32);
        chk("arst_rd_valid", longint'(rd_valid), 0, 0);
        chk("arst_meas_ch", longint'(meas_ch), 3, 3);
        @(negedge clk);
        rst = 1'b0;
        push(1, 20, 20);
        sb_next("post_rst", cyc);

        // gate_cycles == 0 selects the default 20-cycle gate.
        gate_cycles = 32'd0; ch_en = 4'b0001;
        push(0, 10, 10);
        push(0, 10, 10);
        sb_next("defgate", cyc);
        sb_next("defgate", cyc);
        chk("defgate_period", cyc, 26, 26);
        run = 1'b0;

        // Narrow counter saturates one below all-ones.
        run1 = 1'b1; gate_cycles1 = 32'd100; rd_ch1 = 3'd0;
        wait_done(1'b1, 300, cyc, ok);
        chk("sat_done1", longint'(ok), 1, 1);
        chk("sat_data1", longint'(rd_data1), 14, 14);
        chk("sat_valid1", longint'(rd_valid1), 1, 1);
        wait_done(1'b1, 300, cyc, ok);
        chk("sat_done2", longint'(ok), 1, 1);
        chk("sat_period", cyc, 106, 106);
        chk("sat_data2", longint'(rd_data1), 14, 14);
        run1 = 1'b0; rd_ch1 = 3'd7;
        @(negedge clk);
        chk("sat_oor_data", longint'(rd_data1), 15, 15);
        chk("sat_oor_valid", longint'(rd_valid1), 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
